// File: rtl/jelly_wishbone_cmd_sequencer.sv
// WISHBONE master that runs a stream of WRITE / READ / POLL / WAIT register commands.
// All outputs are registered; a dead slave is recovered by an optional ack timeout.
module jelly_wishbone_cmd_sequencer #(
   parameter int unsigned WB_ADR_WIDTH  = 30,
   parameter int unsigned WB_DAT_WIDTH  = 32,
   parameter int unsigned WB_SEL_WIDTH  = WB_DAT_WIDTH / 8,
   parameter int unsigned CMD_ADR_WIDTH = 32,
   parameter int unsigned CNT_WIDTH     = 16
) (
   input  logic                     wb_rst_i,
   input  logic                     wb_clk_i,

   input  logic [1:0]               s_cmd_op,
   input  logic [CMD_ADR_WIDTH-1:0] s_cmd_adr,
   input  logic [WB_DAT_WIDTH-1:0]  s_cmd_dat,
   input  logic [WB_DAT_WIDTH-1:0]  s_cmd_mask,
   input  logic [WB_SEL_WIDTH-1:0]  s_cmd_sel,
   input  logic                     s_cmd_valid,
   output logic                     s_cmd_ready,

   output logic [WB_DAT_WIDTH-1:0]  m_rdata_data,
   output logic                     m_rdata_valid,
   input  logic                     m_rdata_ready,

   output logic [WB_ADR_WIDTH-1:0]  m_wb_adr_o,
   output logic [WB_DAT_WIDTH-1:0]  m_wb_dat_o,
   input  logic [WB_DAT_WIDTH-1:0]  m_wb_dat_i,
   output logic                     m_wb_we_o,
   output logic [WB_SEL_WIDTH-1:0]  m_wb_sel_o,
   output logic                     m_wb_stb_o,
   input  logic                     m_wb_ack_i,

   input  logic [CNT_WIDTH-1:0]     param_poll_interval,
   input  logic [CNT_WIDTH-1:0]     param_poll_limit,
   input  logic [CNT_WIDTH-1:0]     param_ack_timeout,

   input  logic                     clear_err,
   output logic                     busy,
   output logic                     err_timeout,
   output logic                     err_poll
);

   localparam logic [1:0] OpWrite = 2'd0;
   localparam logic [1:0] OpRead  = 2'd1;
   localparam logic [1:0] OpPoll  = 2'd2;
   localparam logic [1:0] OpWait  = 2'd3;

   typedef enum logic [2:0] {StIdle, StBus, StResult, StPollGap, StDelay} state_t;

   state_t                    r_state, w_state;
   logic [1:0]                r_op, w_op;
   logic [WB_DAT_WIDTH-1:0]   r_expect, w_expect;
   logic [WB_DAT_WIDTH-1:0]   r_mask, w_mask;
   logic [CNT_WIDTH-1:0]      r_cnt, w_cnt;
   logic [CNT_WIDTH-1:0]      r_tmo_cnt, w_tmo_cnt;
   logic [CNT_WIDTH-1:0]      r_attempt, w_attempt;
   logic [WB_ADR_WIDTH-1:0]   r_wb_adr, w_wb_adr;
   logic [WB_DAT_WIDTH-1:0]   r_wb_dat, w_wb_dat;
   logic                      r_wb_we, w_wb_we;
   logic [WB_SEL_WIDTH-1:0]   r_wb_sel, w_wb_sel;
   logic                      r_wb_stb, w_wb_stb;
   logic [WB_DAT_WIDTH-1:0]   r_rdata, w_rdata;
   logic                      r_rvalid, w_rvalid;
   logic                      r_ready, r_busy;
   logic                      r_err_tmo, w_err_tmo;
   logic                      r_err_poll, w_err_poll;

   logic                      w_accept;
   logic                      w_match;
   logic                      w_tmo_hit;
   logic                      w_set_tmo, w_set_poll;
   logic [CNT_WIDTH-1:0]      w_tmo_inc;
   logic [CNT_WIDTH-1:0]      w_attempt_inc;
   logic                      w_unused;

   assign w_accept      = s_cmd_valid & r_ready;
   assign w_match       = ((m_wb_dat_i ^ r_expect) & r_mask) == '0;
   assign w_tmo_inc     = r_tmo_cnt + CNT_WIDTH'(1);
   assign w_attempt_inc = r_attempt + CNT_WIDTH'(1);
   // Counter holds cycles already spent with stb high, so this fires on the last allowed one.
   assign w_tmo_hit     = (param_ack_timeout != '0) && (w_tmo_inc == param_ack_timeout);
   assign w_unused      = ^s_cmd_adr[1:0];

   always_comb begin
      w_state    = r_state;
      w_op       = r_op;
      w_expect   = r_expect;
      w_mask     = r_mask;
      w_cnt      = r_cnt;
      w_tmo_cnt  = r_tmo_cnt;
      w_attempt  = r_attempt;
      w_wb_adr   = r_wb_adr;
      w_wb_dat   = r_wb_dat;
      w_wb_we    = r_wb_we;
      w_wb_sel   = r_wb_sel;
      w_wb_stb   = r_wb_stb;
      w_rdata    = r_rdata;
      w_rvalid   = r_rvalid;
      w_set_tmo  = 1'b0;
      w_set_poll = 1'b0;

      case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_op = s_cmd_op;
               if (s_cmd_op == OpWait) begin
                  w_state = StDelay;
                  w_cnt   = s_cmd_dat[CNT_WIDTH-1:0];
               end else begin
                  w_state   = StBus;
                  w_wb_adr  = s_cmd_adr[WB_ADR_WIDTH+1:2];
                  w_wb_dat  = s_cmd_dat;
                  w_wb_we   = (s_cmd_op == OpWrite);
                  w_wb_sel  = (s_cmd_op == OpWrite) ? s_cmd_sel : '1;
                  w_wb_stb  = 1'b1;
                  w_expect  = s_cmd_dat;
                  w_mask    = s_cmd_mask;
                  w_tmo_cnt = '0;
                  w_attempt = '0;
               end
            end
         end

         StBus: begin
            if (m_wb_ack_i) begin
               w_wb_stb = 1'b0;
               case (r_op)
                  OpRead: begin
                     w_state  = StResult;
                     w_rdata  = m_wb_dat_i;
                     w_rvalid = 1'b1;
                  end
                  OpPoll: begin
                     if (w_match) begin
                        w_state = StIdle;
                     end else begin
                        w_attempt = w_attempt_inc;
                        if ((param_poll_limit != '0) && (w_attempt_inc == param_poll_limit)) begin
                           w_set_poll = 1'b1;
                           w_state    = StIdle;
                        end else begin
                           w_state = StPollGap;
                           w_cnt   = param_poll_interval;
                        end
                     end
                  end
                  default: w_state = StIdle;
               endcase
            end else if (w_tmo_hit) begin
               w_wb_stb  = 1'b0;
               w_set_tmo = 1'b1;
               if (r_op == OpRead) begin
                  w_state  = StResult;
                  w_rdata  = '0;
                  w_rvalid = 1'b1;
               end else begin
                  w_state = StIdle;
               end
            end else begin
               w_tmo_cnt = w_tmo_inc;
            end
         end

         StResult: begin
            if (m_rdata_ready) begin
               w_rvalid = 1'b0;
               w_state  = StIdle;
            end
         end

         StPollGap: begin
            if (r_cnt == '0) begin
               w_wb_stb  = 1'b1;
               w_tmo_cnt = '0;
               w_state   = StBus;
            end else begin
               w_cnt = r_cnt - CNT_WIDTH'(1);
            end
         end

         StDelay: begin
            if (r_cnt == '0) begin
               w_state = StIdle;
            end else begin
               w_cnt = r_cnt - CNT_WIDTH'(1);
            end
         end

         default: w_state = StIdle;
      endcase

      // A set in the same cycle as clear_err wins.
      w_err_tmo  = w_set_tmo  | (r_err_tmo  & ~clear_err);
      w_err_poll = w_set_poll | (r_err_poll & ~clear_err);
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         r_state    <= StIdle;
         r_op       <= OpWrite;
         r_expect   <= '0;
         r_mask     <= '0;
         r_cnt      <= '0;
         r_tmo_cnt  <= '0;
         r_attempt  <= '0;
         r_wb_adr   <= '0;
         r_wb_dat   <= '0;
         r_wb_we    <= 1'b0;
         r_wb_sel   <= '0;
         r_wb_stb   <= 1'b0;
         r_rdata    <= '0;
         r_rvalid   <= 1'b0;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_err_tmo  <= 1'b0;
         r_err_poll <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_op       <= w_op;
         r_expect   <= w_expect;
         r_mask     <= w_mask;
         r_cnt      <= w_cnt;
         r_tmo_cnt  <= w_tmo_cnt;
         r_attempt  <= w_attempt;
         r_wb_adr   <= w_wb_adr;
         r_wb_dat   <= w_wb_dat;
         r_wb_we    <= w_wb_we;
         r_wb_sel   <= w_wb_sel;
         r_wb_stb   <= w_wb_stb;
         r_rdata    <= w_rdata;
         r_rvalid   <= w_rvalid;
         r_ready    <= (w_state == StIdle);
         r_busy     <= (w_state != StIdle);
         r_err_tmo  <= w_err_tmo;
         r_err_poll <= w_err_poll;
      end
   end

   assign s_cmd_ready   = r_ready;
   assign busy          = r_busy;
   assign m_wb_adr_o    = r_wb_adr;
   assign m_wb_dat_o    = r_wb_dat;
   assign m_wb_we_o     = r_wb_we;
   assign m_wb_sel_o    = r_wb_sel;
   assign m_wb_stb_o    = r_wb_stb;
   assign m_rdata_data  = r_rdata;
   assign m_rdata_valid = r_rvalid;
   assign err_timeout   = r_err_tmo;
   assign err_poll      = r_err_poll;

endmodule

// File: tb/tb_jelly_wishbone_cmd_sequencer.sv
// Scoreboard bench: expected bus transfers and read results are queued by a command-level
// model; monitors pop and compare whenever the DUT completes a transfer or hands over data.
module tb_jelly_wishbone_cmd_sequencer;
   localparam int AW = 30, DW = 32, SW = 4, CAW = 32, CW = 16;
   localparam logic [AW-1:0] STATUS_WADR = 30'h1000_8405;
   localparam logic [31:0]   STATUS_BADR = 32'h4002_1014;

   logic           wb_rst_i = 1'b0, wb_clk_i = 1'b0;
   logic [1:0]     s_cmd_op = 2'd0;
   logic [CAW-1:0] s_cmd_adr = '0;
   logic [DW-1:0]  s_cmd_dat = '0, s_cmd_mask = '0;
   logic [SW-1:0]  s_cmd_sel = '0;
   logic           s_cmd_valid = 1'b0, s_cmd_ready;
   logic [DW-1:0]  m_rdata_data;
   logic           m_rdata_valid, m_rdata_ready = 1'b0;
   logic [AW-1:0]  m_wb_adr_o;
   logic [DW-1:0]  m_wb_dat_o, m_wb_dat_i;
   logic           m_wb_we_o, m_wb_stb_o, m_wb_ack_i;
   logic [SW-1:0]  m_wb_sel_o;
   logic [CW-1:0]  param_poll_interval = '0, param_poll_limit = '0, param_ack_timeout = '0;
   logic           clear_err = 1'b0, busy, err_timeout, err_poll;

   jelly_wishbone_cmd_sequencer #(
      .WB_ADR_WIDTH(AW), .WB_DAT_WIDTH(DW), .WB_SEL_WIDTH(SW), .CMD_ADR_WIDTH(CAW),
      .CNT_WIDTH(CW)
   ) u_dut (
      .wb_rst_i(wb_rst_i), .wb_clk_i(wb_clk_i),
      .s_cmd_op(s_cmd_op), .s_cmd_adr(s_cmd_adr), .s_cmd_dat(s_cmd_dat),
      .s_cmd_mask(s_cmd_mask), .s_cmd_sel(s_cmd_sel), .s_cmd_valid(s_cmd_valid),
      .s_cmd_ready(s_cmd_ready),
      .m_rdata_data(m_rdata_data), .m_rdata_valid(m_rdata_valid), .m_rdata_ready(m_rdata_ready),
      .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_dat_i(m_wb_dat_i),
      .m_wb_we_o(m_wb_we_o), .m_wb_sel_o(m_wb_sel_o), .m_wb_stb_o(m_wb_stb_o),
      .m_wb_ack_i(m_wb_ack_i),
      .param_poll_interval(param_poll_interval), .param_poll_limit(param_poll_limit),
      .param_ack_timeout(param_ack_timeout),
      .clear_err(clear_err), .busy(busy), .err_timeout(err_timeout), .err_poll(err_poll)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int vectors = 0, miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- slave model ----------------
   logic          slave_dead = 1'b0, junk_en = 1'b0;
   int            min_ws = 0, max_ws = 0, wcnt = 0, ws_cur = 0;
   int            st_cnt = 0, st_target = 0;
   logic [31:0]   mem [16] = '{default: 32'h0};
   logic [31:0]   junk = 32'h0;

   assign m_wb_ack_i = m_wb_stb_o && !slave_dead && (wcnt >= ws_cur);
   assign m_wb_dat_i = (m_wb_adr_o == STATUS_WADR) ? {junk[31:1], st_cnt < st_target}
                                                   : mem[m_wb_adr_o[3:0]];

   always @(posedge wb_clk_i) begin
      junk <= junk_en ? $urandom : 32'h0;
      if (m_wb_stb_o && !m_wb_ack_i) wcnt <= wcnt + 1;
      else begin
         wcnt   <= 0;
         ws_cur <= $urandom_range(max_ws, min_ws);
      end
      if (m_wb_stb_o && m_wb_ack_i) begin
         if (m_wb_we_o) begin
            for (int b = 0; b < 4; b++)
               if (m_wb_sel_o[b]) mem[m_wb_adr_o[3:0]][8*b +: 8] <= m_wb_dat_o[8*b +: 8];
         end else if (m_wb_adr_o == STATUS_WADR) begin
            st_cnt <= st_cnt + 1;
         end
      end
   end

   // Result consumer: 0 = hold ready low, 1 = random, 2 = always ready.
   int rd_mode = 2;
   initial forever begin
      @(posedge wb_clk_i);
      #1;
      m_rdata_ready = (rd_mode == 2) ? 1'b1 : (rd_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [AW-1:0] adr;
      logic          we;
      logic [SW-1:0] sel;
      logic [DW-1:0] dat;
   } bus_t;

   bus_t        exp_bus[$];
   logic [31:0] exp_rd[$];
   bus_t        e_bus;
   logic [31:0] e_rd;

   int   cyc = 0, stb_hi_cnt = 0;
   logic stb_prev = 1'b0;
   int   rise_times[$];

   always @(posedge wb_clk_i) cyc <= cyc + 1;

   always @(negedge wb_clk_i) begin
      stb_prev <= m_wb_stb_o;
      if (m_wb_stb_o) stb_hi_cnt <= stb_hi_cnt + 1;
      if (m_wb_stb_o && !stb_prev) rise_times.push_back(cyc);
      if (wb_rst_i && m_wb_stb_o && m_wb_ack_i) begin
         if (exp_bus.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL bus_unexpected: got transfer adr %h, expected none", m_wb_adr_o);
         end else begin
            e_bus = exp_bus.pop_front();
            check("bus_adr", 32'(m_wb_adr_o), 32'(e_bus.adr));
            check("bus_we", 32'(m_wb_we_o), 32'(e_bus.we));
            check("bus_sel", 32'(m_wb_sel_o), 32'(e_bus.sel));
            if (e_bus.we) check("bus_dat", m_wb_dat_o, e_bus.dat);
         end
      end
      if (wb_rst_i && m_rdata_valid && m_rdata_ready) begin
         if (exp_rd.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL rdata_unexpected: got %h, expected none", m_rdata_data);
         end else begin
            e_rd = exp_rd.pop_front();
            check("rdata", m_rdata_data, e_rd);
         end
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] model_mem [16] = '{default: 32'h0};
   logic        model_err_poll = 1'b0;

   task automatic push_bus(input logic [31:0] badr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat);
      bus_t t;
      t.adr = badr[31:2]; t.we = we; t.sel = sel; t.dat = dat;
      exp_bus.push_back(t);
   endtask

   task automatic model_cmd(input logic [1:0] op, input logic [31:0] badr,
                            input logic [31:0] dat, input logic [3:0] sel, input int k);
      int lim, reads;
      case (op)
         2'd0: begin
            push_bus(badr, 1'b1, sel, dat);
            for (int b = 0; b < 4; b++)
               if (sel[b]) model_mem[badr[5:2]][8*b +: 8] = dat[8*b +: 8];
         end
         2'd1: begin
            push_bus(badr, 1'b0, 4'hF, 32'h0);
            exp_rd.push_back(model_mem[badr[5:2]]);
         end
         2'd2: begin
            lim = int'(param_poll_limit);
            if (lim != 0 && k >= lim) begin
               reads = lim;
               model_err_poll = 1'b1;
            end else reads = k + 1;
            for (int r = 0; r < reads; r++) push_bus(badr, 1'b0, 4'hF, 32'h0);
            st_target = st_cnt + k;
         end
         default: ;
      endcase
   endtask

   task automatic send(input logic [1:0] op, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [31:0] mask, input logic [3:0] sel);
      int n = 0;
      s_cmd_op = op; s_cmd_adr = adr; s_cmd_dat = dat; s_cmd_mask = mask; s_cmd_sel = sel;
      s_cmd_valid = 1'b1;
      @(posedge wb_clk_i);
      while (!s_cmd_ready) begin
         n++;
         if (n > 5000) begin
            $display("FAIL send_accept: got no ready, expected ready within 5000 cycles");
            $fatal(1);
         end
         @(posedge wb_clk_i);
      end
      #1 s_cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 5000) begin
         @(posedge wb_clk_i);
         #1 n++;
      end
      check("idle_in_budget", 32'(busy), 32'h0);
   endtask

   task automatic pulse_clear();
      clear_err = 1'b1;
      @(posedge wb_clk_i);
      #1 clear_err = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   int n_hi, start, cnt, k;
   logic [1:0]  op;
   logic [31:0] adr, dat;
   logic [3:0]  sel;

   initial begin
      #23;
      check("rst_stb", 32'(m_wb_stb_o), 0);
      check("rst_ready", 32'(s_cmd_ready), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_valid", 32'(m_rdata_valid), 0);
      check("rst_errs", 32'({err_timeout, err_poll}), 0);
      check("rst_adr", 32'(m_wb_adr_o), 0);
      check("rst_rdata", m_rdata_data, 0);
      @(posedge wb_clk_i);
      #3 wb_rst_i = 1'b1;

      // Zero-wait WRITE timing.
      min_ws = 0; max_ws = 0;
      @(posedge wb_clk_i); #1;
      model_cmd(2'd0, 32'h4001_0040, 32'd2048, 4'hF, 0);
      send(2'd0, 32'h4001_0040, 32'd2048, 32'h0, 4'hF);
      check("wr_stb_t1", 32'(m_wb_stb_o), 1);
      check("wr_adr", 32'(m_wb_adr_o), 32'h1000_4010);
      check("wr_we", 32'(m_wb_we_o), 1);
      check("wr_ready_t1", 32'(s_cmd_ready), 0);
      @(posedge wb_clk_i); #1;
      check("wr_stb_t2", 32'(m_wb_stb_o), 0);
      check("wr_ready_t2", 32'(s_cmd_ready), 1);
      check("wr_adr_hold", 32'(m_wb_adr_o), 32'h1000_4010);

      // READ with 3 wait states and a stalled consumer.
      model_cmd(2'd0, 32'h4002_1000, 32'h527A_0120, 4'hF, 0);
      send(2'd0, 32'h4002_1000, 32'h527A_0120, 32'h0, 4'hF);
      wait_idle();
      min_ws = 3; max_ws = 3; rd_mode = 0;
      @(posedge wb_clk_i); #1;
      model_cmd(2'd1, 32'h4002_1000, 32'h0, 4'h0, 0);
      send(2'd1, 32'h4002_1000, 32'h0, 32'h0, 4'h0);
      n_hi = 0;
      while (!m_rdata_valid && n_hi < 50) begin
         @(posedge wb_clk_i); #1 n_hi++;
      end
      check("rd_valid_rise", 32'(m_rdata_valid), 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge wb_clk_i); #2;
         check("rd_valid_hold", 32'(m_rdata_valid), 1);
         check("rd_data_hold", m_rdata_data, 32'h527A_0120);
      end
      rd_mode = 2;
      wait_idle();
      check("rd_valid_drop", 32'(m_rdata_valid), 0);

      // POLL: 4 non-matching reads then a match, interval 10.
      min_ws = 0; max_ws = 0; junk_en = 1'b0;
      param_poll_interval = 16'd10; param_poll_limit = 16'd0;
      start = rise_times.size();
      model_cmd(2'd2, STATUS_BADR, 32'h0, 4'h0, 4);
      send(2'd2, STATUS_BADR, 32'h0, 32'hFFFF_FFFF, 4'h0);
      wait_idle();
      st_target = st_cnt;
      check("poll_pulses", 32'(rise_times.size() - start), 5);
      for (int i = 1; i < 5 && start + i < rise_times.size(); i++)
         check("poll_period", 32'(rise_times[start+i] - rise_times[start+i-1]), 12);
      check("poll_err0", 32'(err_poll), 0);

      // POLL stuck at 1, limit 3, clear_err held across the set.
      param_poll_limit = 16'd3; param_poll_interval = 16'd1;
      start = rise_times.size();
      model_cmd(2'd2, STATUS_BADR, 32'h0, 4'h0, 100);
      clear_err = 1'b1;
      send(2'd2, STATUS_BADR, 32'h0, 32'hFFFF_FFFF, 4'h0);
      n_hi = 0;
      while (!err_poll && n_hi < 200) begin
         @(posedge wb_clk_i); #1 n_hi++;
      end
      clear_err = 1'b0;
      check("poll_err_set_wins", 32'(err_poll), 1);
      @(posedge wb_clk_i); #1;
      check("poll_err_sticky", 32'(err_poll), 1);
      pulse_clear();
      model_err_poll = 1'b0;
      check("poll_err_cleared", 32'(err_poll), 0);
      wait_idle();
      st_target = st_cnt;
      check("poll_limit_reads", 32'(rise_times.size() - start), 3);

      // Dead slave READ with timeout 1024, then a normal WRITE.
      slave_dead = 1'b1; param_ack_timeout = 16'd1024;
      n_hi = stb_hi_cnt;
      exp_rd.push_back(32'h0);
      send(2'd1, 32'h4000_0008, 32'h0, 32'h0, 4'h0);
      wait_idle();
      check("tmo_stb_cycles", 32'(stb_hi_cnt - n_hi), 1024);
      check("tmo_err", 32'(err_timeout), 1);
      slave_dead = 1'b0;
      pulse_clear();
      check("tmo_err_cleared", 32'(err_timeout), 0);
      model_cmd(2'd0, 32'h4000_0008, 32'hA5A5_1234, 4'h5, 0);
      send(2'd0, 32'h4000_0008, 32'hA5A5_1234, 32'h0, 4'h5);
      wait_idle();
      check("tmo_after_wr_err", 32'(err_timeout), 0);

      // WAIT 100 busy length.
      send(2'd3, 32'h0, 32'd100, 32'h0, 4'h0);
      cnt = 0;
      while (busy && cnt < 1000) begin
         cnt++;
         @(posedge wb_clk_i); #1;
      end
      check("wait_busy_cycles", 32'(cnt), 101);

      // Reset during a bus cycle to a dead slave.
      slave_dead = 1'b1; param_ack_timeout = 16'd0;
      send(2'd0, 32'h4000_000C, 32'h1, 32'h0, 4'hF);
      @(posedge wb_clk_i); #2;
      wb_rst_i = 1'b0;
      #1;
      check("rst_async_stb", 32'(m_wb_stb_o), 0);
      @(posedge wb_clk_i); #3;
      wb_rst_i = 1'b1;
      slave_dead = 1'b0;
      @(posedge wb_clk_i); #1;
      check("rst_rel_ready", 32'(s_cmd_ready), 1);
      check("rst_rel_busy", 32'(busy), 0);

      // Randomised command stream.
      for (int n = 0; n < 60; n++) begin
         min_ws = 0; max_ws = $urandom_range(0, 3); rd_mode = 1; junk_en = 1'b1;
         param_poll_interval = CW'($urandom_range(0, 3));
         param_poll_limit    = CW'($urandom_range(0, 4));
         param_ack_timeout   = CW'($urandom_range(6, 20));
         op  = 2'($urandom_range(0, 3));
         adr = 32'h4000_0000 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
         dat = $urandom;
         sel = 4'($urandom_range(0, 15));
         k   = $urandom_range(0, 4);
         case (op)
            2'd2: begin
               dat = $urandom & 32'hFFFF_FFFE;
               model_cmd(op, STATUS_BADR, dat, sel, k);
               send(op, STATUS_BADR, dat, 32'h1, sel);
            end
            2'd3: begin
               dat = 32'($urandom_range(0, 5));
               send(op, adr, dat, 32'h0, sel);
            end
            default: begin
               model_cmd(op, adr, dat, sel, 0);
               send(op, adr, dat, 32'h0, sel);
            end
         endcase
         wait_idle();
         st_target = st_cnt;
         check("rnd_err_poll", 32'(err_poll), 32'(model_err_poll));
         check("rnd_err_tmo", 32'(err_timeout), 0);
         if (model_err_poll) begin
            pulse_clear();
            model_err_poll = 1'b0;
         end
      end

      repeat (4) @(posedge wb_clk_i);
      check("bus_queue_empty", 32'(exp_bus.size()), 0);
      check("rd_queue_empty", 32'(exp_rd.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
